// File: rtl/flux_fifo_pkg.sv
// rtl/flux_fifo_pkg.sv - shared defaults and tag-width helper for the tagged flux FIFO
package flux_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 7;
  localparam int DEFAULT_DEPTH      = 4;

  // A single flux would need zero tag bits; clamp so slices stay legal.
  function automatic int tag_width(input int flux);
    return (flux < 2) ? 1 : $clog2(flux);
  endfunction

endpackage

// File: rtl/flux_fifo_queue.sv
// rtl/flux_fifo_queue.sv - single-flux FIFO with qualified push/pop, occupancy count and fall-through head
module flux_fifo_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is deliberately left out of reset; only pointers and count clear.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/tagged_flux_fifo.sv
// rtl/tagged_flux_fifo.sv - per-tag FIFO bank with lowest-index head selection; TAGGED_FLUX_FIFO_ERR_EN adds sticky error flags
module tagged_flux_fifo
  import flux_fifo_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int TAG_WIDTH  = tag_width(FLUX),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [WIDTH-1:0]  din,
  output logic              full,
  input  logic [FLUX-1:0]   read,
  output logic [FLUX-1:0]   empty,
`ifdef TAGGED_FLUX_FIFO_ERR_EN
  output logic              err_overflow,
  output logic              err_underflow,
`endif
  output logic [WIDTH-1:0]  dout
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [TAG_WIDTH-1:0]          tag;
  logic                          tag_ok;
  logic [FLUX-1:0]               push;
  logic [FLUX-1:0]               pop;
  logic [FLUX-1:0]               at_depth;
  logic [FLUX-1:0][CW-1:0]       count;
  logic [FLUX-1:0][WIDTH-1:0]    head;
  logic [TAG_WIDTH-1:0]          sel;

  assign tag    = din[WIDTH-1 -: TAG_WIDTH];
  assign tag_ok = int'(tag) < FLUX;

  // Any full queue stalls the producer because the next tag is unknown.
  assign full = |at_depth;

  for (genvar i = 0; i < FLUX; i++) begin : g_queue
    assign at_depth[i] = (count[i] == CW'(DEPTH));
    assign empty[i]    = (count[i] == '0);
    assign push[i]     = write && !full && tag_ok && (int'(tag) == i);
    assign pop[i]      = read[i] && !empty[i];

    flux_fifo_queue #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (din),
      .count (count[i]),
      .head  (head[i])
    );
  end

  always_comb begin
    sel = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (!empty[i]) sel = TAG_WIDTH'(i);
    end
  end

  assign dout = head[sel];

`ifdef TAGGED_FLUX_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (write && (full || !tag_ok)) err_overflow  <= 1'b1;
      if (|(read & empty))            err_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/tagged_flux_fifo.md
TAGGED_FLUX_FIFO -- requirements
Module: tagged_flux_fifo

Interface
REQ-001 SHALL have parameter FLUX, default 2, meaning the number of independent data fluxes; legal values are 2 or more.
REQ-002 SHALL have parameter DATA_WIDTH, default 7, meaning payload bits per word, excluding the tag.
REQ-003 SHALL have parameter DEPTH, default 4, meaning words per flux queue; it SHALL be a power of 2 and at least 2.
REQ-004 Port widths: TAG_WIDTH = $clog2(FLUX) and WIDTH = DATA_WIDTH + TAG_WIDTH.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 wr_port.write  input  1  write request from the producing actor.
REQ-008 wr_port.din  input  WIDTH  {tag, payload}; the tag occupies the MSBs.
REQ-009 wr_port.full  output  1  write backpressure to the producing actor.
REQ-010 rd_port.read  input  FLUX  per-flux pop request from the consuming actor.
REQ-011 rd_port.empty  output  FLUX  per-flux empty flag.
REQ-012 rd_port.dout  output  WIDTH  {tag, payload} of the selected head word.

Function
REQ-013 SHALL keep one FIFO queue per flux, each DEPTH deep, with an occupancy counter of width $clog2(DEPTH)+1.
REQ-014 On write=1 and full=0, SHALL push din into the queue selected by din[WIDTH-1 -: TAG_WIDTH], storing the whole word, tag included.
REQ-015 A write with a tag value of FLUX or more SHALL be dropped, and the state SHALL be left unchanged.
REQ-016 full SHALL be 1 when any queue holds DEPTH words; this is conservative because the consumer does not know the next tag.
REQ-017 A write while full=1 SHALL be ignored, and no queue SHALL change.
REQ-018 empty[i] SHALL be 1 exactly when the occupancy of queue i is 0.
REQ-019 Selection: sel is the lowest index i with empty[i]=0, or 0 if all queues are empty.
REQ-020 dout SHALL be the head word of queue sel (first-word fall-through); dout is don't-care when empty[sel]=1.
REQ-021 On read[i]=1 and empty[i]=0, SHALL pop queue i; read[i]=1 with empty[i]=1 SHALL be ignored.
REQ-022 More than one read bit may be asserted; each qualifying queue SHALL pop independently.
REQ-023 Push and pop on the same queue in the same cycle SHALL both take effect, leaving the count unchanged; this is allowed even at count=DEPTH-1 and count=1.
REQ-024 Latency: a pushed word SHALL appear on empty/dout in the cycle after the push edge; full and empty SHALL be derived combinationally from registered counters.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH without losing data.

Reset
REQ-026 When rst_n=0 at a clock edge, SHALL clear all pointers and counters, giving empty = all ones and full = 0.
REQ-027 Storage contents SHALL NOT be reset.
REQ-028 Reset asserted mid-operation SHALL discard all queued words.
REQ-029 A write or read in a reset cycle SHALL have no effect.

Configuration
REQ-030 With macro TAGGED_FLUX_FIFO_ERR_EN defined, SHALL add output ports err_overflow (1 bit) and err_underflow (1 bit).
REQ-031 err_overflow SHALL be sticky, set by a write while full or by a write with an illegal tag.
REQ-032 err_underflow SHALL be sticky, set by read[i]=1 while empty[i]=1.
REQ-033 Both error flags SHALL be cleared only by reset.
REQ-034 Without the macro, the error ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Package flux_fifo_pkg SHALL hold the default DATA_WIDTH and DEPTH constants and a tag-width helper function.
REQ-036 One sub-module, flux_fifo_queue (a single-flux FIFO with push, pop, count and head), SHALL be instantiated FLUX times in a generate loop.
REQ-037 Top-level logic SHALL be limited to tag decode, full/empty aggregation, sel priority and the dout mux.

Verification (FLUX=2, DATA_WIDTH=7, DEPTH=4)
REQ-038 Reset: hold rst_n=0 for 2 cycles -> empty=2'b11, full=0.
REQ-039 Single flux: write 0x85 (tag 1, payload 5) -> next cycle empty=2'b01 and dout=0x85; then read=2'b10 -> empty=2'b11.
REQ-040 Priority: write tag1/3 then tag0/9 -> dout={0,9}; pop flux 0 -> dout={1,3}.
REQ-041 Full and wrap:
- Write tag0 payloads 1..4 -> full=1; a 5th write is dropped.
- Pop one, write payload 5 -> pop order is 2,3,4,5.
REQ-042 Simultaneous events: at count=4, the write is blocked even with a same-cycle pop; at count=3, push and pop in the same cycle -> count stays 3 and full=0.
REQ-043 Errors and reset:
- With TAGGED_FLUX_FIFO_ERR_EN defined, read=2'b01 on an empty queue -> err_underflow=1 and it stays set.
- Reset mid-fill -> all queues empty and both error flags 0.
